// File: rtl/mac_rr_scheduler_if.sv
// Job request, element stream and result bus between vector producers,
// result consumers and the shared MAC scheduler.
interface mac_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 64,
    parameter int LW   = 5,
    parameter int IW   = $clog2(NREQ)
);
    // Every stream is valid/ready: a transfer happens on a clock edge where
    // both are high; the source holds its payload stable until then.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    in_valid;
    logic [NREQ*DW-1:0] in_a;
    logic [NREQ*DW-1:0] in_b;
    logic [NREQ-1:0]    in_ready;
    logic               res_valid;
    logic               res_ready;
    logic [AW-1:0]      res_data;
    logic [IW-1:0]      res_id;
    logic               res_sat;
    logic               busy;

    modport master (
        output req_valid, req_len, in_valid, in_a, in_b, res_ready,
        input  grant, in_ready, res_valid, res_data, res_id, res_sat, busy
    );

    modport slave (
        input  req_valid, req_len, in_valid, in_a, in_b, res_ready,
        output grant, in_ready, res_valid, res_data, res_id, res_sat, busy
    );
endinterface

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one signed multiply-accumulate datapath.
// Define MAC_SAT_EN for a saturating accumulator and a sticky res_sat flag.
module mac_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int DW     = 32,
    parameter int AW     = 64,
    parameter int MAXLEN = 16,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    mac_rr_scheduler_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

    state_t                 state;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          idx;
    logic [LW-1:0]          len;
    logic [LW-1:0]          count;
    logic                   drain_cnt;
    logic [NREQ-1:0]        grant_q;
    logic [NREQ-1:0]        in_ready_q;
    logic                   res_valid_q;
    logic [AW-1:0]          res_data_q;
    logic [IW-1:0]          res_id_q;
    logic                   res_sat_q;
    logic [AW-1:0]          acc;
    logic signed [2*DW-1:0] prod_q;
    logic                   prod_v;

    logic                   hi_found, lo_found;
    logic [IW-1:0]          hi_idx, lo_idx, sel_idx;
    logic [LW-1:0]          sel_len, sel_len_c;
    logic                   accept;
    logic signed [DW-1:0]   cur_a, cur_b;
    logic signed [AW-1:0]   prod_ext;
    logic [AW-1:0]          acc_next;

    // Arbitration: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        sel_len  = '0;
        accept   = 1'b0;
        cur_a    = '0;
        cur_b    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(j);
                if (j >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(j);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
        for (int j = 0; j < NREQ; j++) begin
            if (IW'(j) == sel_idx) sel_len = bus.req_len[j*LW +: LW];
            if (IW'(j) == idx) begin
                accept = bus.in_valid[j] & in_ready_q[j];
                cur_a  = bus.in_a[j*DW +: DW];
                cur_b  = bus.in_b[j*DW +: DW];
            end
        end
        sel_len_c = (sel_len > LW'(MAXLEN)) ? LW'(MAXLEN) : sel_len;
    end

    assign prod_ext = AW'(prod_q);

`ifdef MAC_SAT_EN
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    logic [AW:0] sum_wide;
    logic        ovf;
    logic        job_sat;

    // One guard bit detects signed overflow; clip toward the sign of the true sum.
    always_comb begin
        sum_wide = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
        ovf      = sum_wide[AW] ^ sum_wide[AW-1];
        if (ovf) acc_next = sum_wide[AW] ? ACC_MIN : ACC_MAX;
        else     acc_next = sum_wide[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_sat <= 1'b0;
        end else if (state == IDLE && lo_found) begin
            job_sat <= 1'b0;
        end else if (prod_v && ovf) begin
            job_sat <= 1'b1;
        end
    end
`else
    assign acc_next = acc + prod_ext;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idx         <= '0;
            len         <= '0;
            count       <= '0;
            drain_cnt   <= 1'b0;
            grant_q     <= '0;
            in_ready_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_sat_q   <= 1'b0;
            acc         <= '0;
            prod_q      <= '0;
            prod_v      <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) prod_q <= (2*DW)'(cur_a) * (2*DW)'(cur_b);
            if (prod_v) acc <= acc_next;
            case (state)
                IDLE: begin
                    if (lo_found) begin
                        idx       <= sel_idx;
                        len       <= sel_len_c;
                        count     <= '0;
                        grant_q   <= NREQ'(1) << sel_idx;
                        acc       <= '0;
                        res_sat_q <= 1'b0;
                        if (sel_len_c == '0) begin
                            state       <= RESULT;
                            res_valid_q <= 1'b1;
                            res_data_q  <= '0;
                            res_id_q    <= sel_idx;
                        end else begin
                            state      <= STREAM;
                            in_ready_q <= NREQ'(1) << sel_idx;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == len - 1'b1) begin
                            in_ready_q <= '0;
                            drain_cnt  <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Second drain cycle: the last product has reached acc.
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state       <= RESULT;
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc;
                        res_id_q    <= idx;
`ifdef MAC_SAT_EN
                        res_sat_q   <= job_sat;
`endif
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        grant_q     <= '0;
                        rr_ptr      <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_sat   = res_sat_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;
endmodule
